// File: rtl/song_sequencer_pkg.sv
// Shared constants for the song sequencer.
//   - FSM state encodings (plain 3-bit constants so older tools and waveform
//     viewers that decode raw values keep working).
//   - Song ROM word layout: [15] END, [14:13] side, [12:7] note,
//     [6:1] duration, [0] reserved.
package song_sequencer_pkg;

    localparam int ROM_W    = 16;
    localparam int END_BIT  = 15;
    localparam int SIDE_MSB = 14;
    localparam int SIDE_LSB = 13;
    localparam int NOTE_MSB = 12;
    localparam int NOTE_LSB = 7;
    localparam int DUR_MSB  = 6;
    localparam int DUR_LSB  = 1;
    localparam int RSVD_BIT = 0;

    localparam int NOTE_W = NOTE_MSB - NOTE_LSB + 1;
    localparam int DUR_W  = DUR_MSB - DUR_LSB + 1;
    localparam int SIDE_W = SIDE_MSB - SIDE_LSB + 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_LOAD      = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_STOPPED   = 3'd5;

endpackage

// File: rtl/song_sequencer.sv
// Song sequencer: walks a song held in an external synchronous ROM, decodes
// each entry and hands it to the note player, then waits for the player to
// finish before fetching the next entry.
//
// State table:
//   IDLE      | parked, waiting for play
//   FETCH     | rom_addr presented, ROM data arrives next cycle
//   DECODE    | rom_data valid: END handling or capture of note fields
//   LOAD      | load_new_note pulse, entry advances
//   WAIT_DONE | waiting for done_with_note from the player
//   STOPPED   | song finished without looping; only new_song leaves
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   play                  sequencing enable (gated at WAIT_DONE exit / IDLE)
//   song_sel, new_song    song select, latched and restarted on new_song pulse
//   loop_enable           restart at entry 0 after END instead of stopping
//   rom_addr, rom_data    {song, entry} address out, ROM word in (1-cycle latency)
//   note_to_load, duration_to_load, stereo_side_to_load
//                         decoded fields, held until the next load
//   load_new_note         one-cycle load strobe to the player
//   done_with_note        player finished the current note
//   song_done             one-cycle pulse at end of song (END or entry wrap)
//   busy                  high outside IDLE and STOPPED
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int SONG_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play,
    input  logic [SONG_W-1:0]        song_sel,
    input  logic                     new_song,
    input  logic                     loop_enable,
    output logic [SONG_W+ADDR_W-1:0] rom_addr,
    input  logic [ROM_W-1:0]         rom_data,
    output logic [NOTE_W-1:0]        note_to_load,
    output logic [DUR_W-1:0]         duration_to_load,
    output logic [SIDE_W-1:0]        stereo_side_to_load,
    output logic                     load_new_note,
    input  logic                     done_with_note,
    output logic                     song_done,
    output logic                     busy
);

    localparam logic [ADDR_W-1:0] ENTRY_MAX = '1;

    logic [2:0]        state_q, state_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [ADDR_W-1:0] entry_q, entry_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [SIDE_W-1:0] side_q, side_d;
    logic              wrap_q, wrap_d;
    logic              load_pulse;
    logic              done_pulse;

    // Bit 0 of the ROM word is reserved and intentionally not decoded.
    logic unused_rsvd;
    assign unused_rsvd = rom_data[RSVD_BIT];

    always_comb begin
        state_d    = state_q;
        song_d     = song_q;
        entry_d    = entry_q;
        note_d     = note_q;
        dur_d      = dur_q;
        side_d     = side_q;
        wrap_d     = wrap_q;
        load_pulse = 1'b0;
        done_pulse = 1'b0;

        // new_song overrides everything, including a load or END in flight.
        if (new_song) begin
            song_d  = song_sel;
            entry_d = '0;
            wrap_d  = 1'b0;
            state_d = play ? ST_FETCH : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (play) state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    if (rom_data[END_BIT]) begin
                        done_pulse = 1'b1;
                        entry_d    = '0;
                        state_d    = loop_enable ? ST_FETCH : ST_STOPPED;
                    end else begin
                        note_d  = rom_data[NOTE_MSB:NOTE_LSB];
                        dur_d   = rom_data[DUR_MSB:DUR_LSB];
                        side_d  = rom_data[SIDE_MSB:SIDE_LSB];
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load_pulse = 1'b1;
                    entry_d    = entry_q + 1'b1;
                    // Running off the last entry acts as an implicit END; the
                    // loop/stop decision is deferred until this note finishes.
                    if (entry_q == ENTRY_MAX) begin
                        done_pulse = 1'b1;
                        wrap_d     = 1'b1;
                    end
                    state_d = ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (done_with_note) begin
                        wrap_d = 1'b0;
                        if (wrap_q && !loop_enable) state_d = ST_STOPPED;
                        else                        state_d = play ? ST_FETCH : ST_IDLE;
                    end
                end
                ST_STOPPED: begin
                    state_d = ST_STOPPED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            song_q  <= '0;
            entry_q <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            side_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            entry_q <= entry_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            side_q  <= side_d;
            wrap_q  <= wrap_d;
        end
    end

    // Strobes are decoded from the registered state so an asynchronous reset
    // removes them immediately.
    assign load_new_note       = load_pulse;
    assign song_done           = done_pulse;
    assign rom_addr            = {song_q, entry_q};
    assign note_to_load        = note_q;
    assign duration_to_load    = dur_q;
    assign stereo_side_to_load = side_q;
    assign busy                = (state_q != ST_IDLE) && (state_q != ST_STOPPED);

endmodule

// File: tb/tb_song_sequencer.sv
`timescale 1ns/1ps
module tb_song_sequencer;

    typedef struct packed {
        logic [8:0] addr;
        logic [5:0] note;
        logic [5:0] dur;
        logic [1:0] side;
    } ld_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic [1:0]  song_sel;
    logic        new_song;
    logic        loop_enable;
    logic [8:0]  rom_addr;
    logic [15:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic [1:0]  stereo_side_to_load;
    logic        load_new_note;
    logic        done_with_note;
    logic        song_done;
    logic        busy;

    logic [15:0] rom [0:511];
    logic [8:0]  rom_a;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pend = 0;
    int dmin = 1;
    int dmax = 1;
    logic extra_done = 1'b0;

    ld_t        obs[$];
    int         ocyc[$];
    int         sd_cyc[$];
    logic [8:0] sd_addr[$];
    int         dn_cyc[$];
    ld_t        exp_q[$];
    int         exp_ends;

    song_sequencer #(.ADDR_W(7), .SONG_W(2)) dut (
        .clk                 (clk),
        .reset               (reset),
        .play                (play),
        .song_sel            (song_sel),
        .new_song            (new_song),
        .loop_enable         (loop_enable),
        .rom_addr            (rom_addr),
        .rom_data            (rom_data),
        .note_to_load        (note_to_load),
        .duration_to_load    (duration_to_load),
        .stereo_side_to_load (stereo_side_to_load),
        .load_new_note       (load_new_note),
        .done_with_note      (done_with_note),
        .song_done           (song_done),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM: data for the address held during a cycle appears
    // in the following cycle.
    always begin
        @(posedge clk);
        rom_a = rom_addr;
        #1 rom_data = rom[rom_a];
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mk(input logic e, input logic [1:0] side,
                                       input logic [5:0] note, input logic [5:0] dur,
                                       input logic rsvd);
        return {e, side, note, dur, rsvd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
        end
    endtask

    // Expected loads from the song content: skip nothing, END or running past
    // entry 127 closes a pass; loop restarts at entry 0, otherwise stop.
    task automatic build_exp(input int song, input bit lp, input int max_loads);
        int e;
        int guard;
        logic [15:0] w;
        ld_t t;
        e = 0;
        guard = 0;
        exp_q.delete();
        exp_ends = 0;
        while (exp_q.size() < max_loads && guard < 4096) begin
            guard++;
            w = rom[song * 128 + e];
            if ((w / 32768) != 0) begin
                exp_ends++;
                e = 0;
                if (!lp) break;
            end else begin
                t.addr = 9'(song * 128 + e);
                t.note = 6'(w / 128);
                t.dur  = 6'(w / 2);
                t.side = 2'(w / 8192);
                exp_q.push_back(t);
                e++;
                if (e == 128) begin
                    exp_ends++;
                    e = 0;
                    if (!lp) break;
                end
            end
        end
    endtask

    function automatic int count_bad();
        int n = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs.size() || obs[i] !== exp_q[i]) n++;
        return n;
    endfunction

    function automatic int ocyc_at(input int i);
        return (i < ocyc.size()) ? ocyc[i] : -1000;
    endfunction

    function automatic int dn_at(input int i);
        return (i < dn_cyc.size()) ? dn_cyc[i] : -1000;
    endfunction

    function automatic logic [31:0] obs_at(input int i);
        return (i < obs.size()) ? 32'(obs[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] addr_at(input int i);
        return (i < obs.size()) ? 32'(obs[i].addr) : 32'hFFFF_FFFF;
    endfunction

    task automatic clear_logs();
        obs.delete(); ocyc.delete(); sd_cyc.delete(); sd_addr.delete(); dn_cyc.delete();
        pend = 0;
    endtask

    // One clock cycle: player drives done, outputs of this cycle are logged,
    // then advance to 2ns after the next rising edge.
    task automatic step();
        done_with_note = (pend == 1) || extra_done;
        if (pend == 1) dn_cyc.push_back(cyc);
        if (pend > 0) pend--;
        #1;
        if (load_new_note === 1'b1) begin
            obs.push_back('{addr: rom_addr, note: note_to_load,
                            dur: duration_to_load, side: stereo_side_to_load});
            ocyc.push_back(cyc);
            pend = int'($urandom_range(dmax, dmin));
        end
        if (song_done === 1'b1) begin
            sd_cyc.push_back(cyc);
            sd_addr.push_back(rom_addr);
        end
        @(posedge clk);
        #2;
        cyc++;
        new_song = 1'b0;
        extra_done = 1'b0;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic run_loads(input int target, input int bound);
        int n = 0;
        while (obs.size() < target && n < bound) begin
            step();
            n++;
        end
        if (obs.size() < target) chk("timeout_loads", 32'(obs.size()), 32'(target));
    endtask

    task automatic run_idle(input int bound);
        int n = 0;
        do begin
            step();
            n++;
        end while (busy === 1'b1 && n < bound);
        if (busy !== 1'b0) chk("timeout_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int base;
        int len0;
        int nbad;
        reset = 1'b1; play = 1'b0; song_sel = 2'd0; new_song = 1'b0;
        loop_enable = 1'b0; done_with_note = 1'b0; rom_data = 16'h0;

        for (int i = 0; i < 512; i++) rom[i] = 16'h8000;
        // song 0: random length, frequent zero durations
        len0 = int'($urandom_range(10, 4));
        for (int i = 0; i < len0; i++)
            rom[i] = mk(1'b0, 2'($urandom_range(3, 1)), 6'($urandom_range(63, 0)),
                        ($urandom_range(1, 0) == 0) ? 6'd0 : 6'($urandom_range(63, 0)),
                        1'($urandom));
        rom[len0] = mk(1'b1, 2'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
        // song 1: directed
        rom[128] = mk(1'b0, 2'b11, 6'd20, 6'd4, 1'b0);
        rom[129] = mk(1'b0, 2'b01, 6'd25, 6'd2, 1'b1);
        rom[130] = mk(1'b1, 2'b00, 6'd0, 6'd0, 1'b0);
        // song 2: 12 random entries then END
        for (int i = 0; i < 12; i++)
            rom[256 + i] = mk(1'b0, 2'($urandom_range(3, 1)), 6'($urandom_range(63, 0)),
                              6'($urandom_range(63, 0)), 1'($urandom));
        // song 3: full 128 entries, no END, duration 1
        for (int i = 0; i < 128; i++)
            rom[384 + i] = mk(1'b0, 2'($urandom_range(3, 1)), 6'($urandom_range(63, 0)),
                              6'd1, 1'($urandom));

        // reset values
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_note", 32'(note_to_load), 32'd0);
        chk("rst_dur", 32'(duration_to_load), 32'd0);
        chk("rst_side", 32'(stereo_side_to_load), 32'd0);
        chk("rst_load", {31'd0, load_new_note}, 32'd0);
        chk("rst_song_done", {31'd0, song_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        step();
        chk("idle_no_play", {31'd0, busy}, 32'd0);

        // basic sequence, song 1, stop at END
        clear_logs();
        dmin = 1; dmax = 4;
        play = 1'b1; loop_enable = 1'b0; song_sel = 2'd1; new_song = 1'b1;
        base = cyc;
        run_idle(100);
        build_exp(1, 1'b0, 1000);
        chk("s1_nloads", 32'(obs.size()), 32'(exp_q.size()));
        chk("s1_fields", 32'(count_bad()), 32'd0);
        chk("s1_addr0", addr_at(0), 32'h080);
        chk("s1_addr1", addr_at(1), 32'h081);
        chk("s1_first_latency", 32'(ocyc_at(0) - base), 32'd3);
        chk("s1_done_to_load", 32'(ocyc_at(1) - dn_at(0)), 32'd3);
        chk("s1_song_done_n", 32'(sd_cyc.size()), 32'(exp_ends));
        chk("s1_end_addr", (sd_addr.size() > 0) ? 32'(sd_addr[0]) : 32'hFFFF_FFFF, 32'h082);
        chk("s1_stopped_addr", 32'(rom_addr), 32'h080);
        repeat (10) step();
        chk("s1_no_restart", 32'(obs.size()), 32'(exp_q.size()));
        chk("s1_stays_stopped", {31'd0, busy}, 32'd0);

        // looping, song 1
        clear_logs();
        dmin = 1; dmax = 3;
        loop_enable = 1'b1; song_sel = 2'd1; new_song = 1'b1;
        run_loads(6, 200);
        build_exp(1, 1'b1, 6);
        chk("s2_fields", 32'(count_bad()), 32'd0);
        chk("s2_song_done_n", 32'(sd_cyc.size()), 32'(exp_ends));
        nbad = 0;
        foreach (sd_addr[i]) if (sd_addr[i] !== 9'h082) nbad++;
        chk("s2_end_addr", 32'(nbad), 32'd0);
        loop_enable = 1'b0;
        run_idle(100);
        chk("s2_final_done_n", 32'(sd_cyc.size()), 32'(exp_ends + 1));
        chk("s2_final_loads", 32'(obs.size()), 32'(exp_q.size()));

        // random song 0, zero durations, done one cycle after each load
        clear_logs();
        dmin = 1; dmax = 1;
        song_sel = 2'd0; new_song = 1'b1;
        run_idle(20 * len0 + 50);
        build_exp(0, 1'b0, 1000);
        chk("s3_nloads", 32'(obs.size()), 32'(exp_q.size()));
        chk("s3_fields", 32'(count_bad()), 32'd0);
        nbad = 0;
        for (int i = 1; i < ocyc.size(); i++) if (ocyc[i] - ocyc[i-1] != 4) nbad++;
        chk("s3_spacing", 32'(nbad), 32'd0);
        chk("s3_song_done_n", 32'(sd_cyc.size()), 32'd1);

        // play gating in WAIT_DONE, song 2
        clear_logs();
        dmin = 4; dmax = 4;
        play = 1'b1; song_sel = 2'd2; new_song = 1'b1;
        run_loads(1, 20);
        play = 1'b0;
        repeat (8) step();
        chk("s4_no_fetch_loads", 32'(obs.size()), 32'd1);
        chk("s4_idle", {31'd0, busy}, 32'd0);
        chk("s4_idle_addr", 32'(rom_addr), 32'h101);
        play = 1'b1;
        run_loads(2, 20);
        build_exp(2, 1'b0, 1000);
        chk("s4_resume_entry", obs_at(1), 32'(exp_q[1]));

        // new_song mid-note: song 3 entry 5 -> song 2
        clear_logs();
        dmin = 6; dmax = 6;
        song_sel = 2'd3; new_song = 1'b1;
        run_loads(6, 100);
        chk("s5_entry5_addr", addr_at(5), 32'h185);
        base = cyc;
        pend = 0;
        song_sel = 2'd2; new_song = 1'b1;
        step();
        chk("s5_new_addr", 32'(rom_addr), 32'h100);
        extra_done = 1'b1;
        step();
        extra_done = 1'b1;
        step();
        dmin = 2; dmax = 2;
        step();
        build_exp(2, 1'b0, 1);
        chk("s5_load_cyc", 32'(ocyc_at(6)), 32'(base + 3));
        chk("s5_load_fields", obs_at(6), 32'(exp_q[0]));
        step_to(base + 8);
        song_sel = 2'd1; new_song = 1'b1;
        step();
        chk("s5_load_suppressed", 32'(obs.size()), 32'd7);
        run_loads(8, 20);
        build_exp(1, 1'b0, 1);
        chk("s5_restart_cyc", 32'(ocyc_at(7)), 32'(base + 11));
        chk("s5_restart_fields", obs_at(7), 32'(exp_q[0]));
        chk("s5_no_song_done", 32'(sd_cyc.size()), 32'd0);

        // entry wrap on song 3 with looping
        clear_logs();
        dmin = 1; dmax = 1;
        loop_enable = 1'b1; song_sel = 2'd3; new_song = 1'b1;
        run_loads(129, 800);
        build_exp(3, 1'b1, 129);
        chk("s6_fields", 32'(count_bad()), 32'd0);
        chk("s6_song_done_n", 32'(sd_cyc.size()), 32'(exp_ends));
        chk("s6_done_on_last", (sd_cyc.size() > 0) ? 32'(sd_cyc[0]) : 32'hFFFF_FFFF,
            32'(ocyc_at(127)));
        chk("s6_after_wrap", addr_at(128), 32'h180);

        // asynchronous reset in a LOAD cycle
        step_to(ocyc_at(128) + 4);
        #1;
        chk("s7_pre_reset_load", {31'd0, load_new_note}, 32'd1);
        reset = 1'b1;
        #1;
        chk("s7_load_cleared", {31'd0, load_new_note}, 32'd0);
        chk("s7_busy_cleared", {31'd0, busy}, 32'd0);
        chk("s7_addr_cleared", 32'(rom_addr), 32'd0);
        chk("s7_note_cleared", 32'(note_to_load), 32'd0);
        chk("s7_no_song_done", {31'd0, song_done}, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        play = 1'b0;
        step();
        chk("s7_idle_after", {31'd0, busy}, 32'd0);
        chk("s7_no_extra_load", 32'(obs.size()), 32'd129);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Upstream stage of the note player.
- Walks a song stored in an external synchronous song ROM and decodes each entry into note, duration and stereo side.
- Hands each entry to the note player with a one-cycle load pulse, then waits for the player's done_with_note before fetching the next entry.
- Handles song selection, end-of-song detection, looping and restart.

Parameters:
- ADDR_W, 7, entry-address width per song (128 entries per song).
- SONG_W, 2, song-select width (4 songs); ROM address width = SONG_W+ADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play  in  1  high = sequencing allowed; low = hold in IDLE or WAIT_DONE
- song_sel  in  SONG_W  song to play; sampled only on new_song
- new_song  in  1  one-cycle pulse: latch song_sel, restart at entry 0
- loop_enable  in  1  high = restart at entry 0 after END instead of stopping
- rom_addr  out  SONG_W+ADDR_W  {song, entry}; registered
- rom_data  in  16  ROM word, valid one cycle after rom_addr changes
- note_to_load  out  6  decoded note; 0 = rest
- duration_to_load  out  6  decoded duration in beats
- stereo_side_to_load  out  2  one-hot/both side mask
- load_new_note  out  1  one-cycle pulse; fields valid the same cycle
- done_with_note  in  1  from note player; single-cycle pulse
- song_done  out  1  one-cycle pulse when the song ends (with or without looping)
- busy  out  1  high in any state except IDLE and STOPPED

Behaviour:
- Reset values: rom_addr=0, all note fields 0, load_new_note=0, song_done=0, busy=0, state=IDLE, latched song=0.
- ROM word format:
  - [15] END flag.
  - [14:13] stereo side.
  - [12:7] note.
  - [6:1] duration.
  - [0] reserved, ignored.
- States: IDLE, FETCH, DECODE, LOAD, WAIT_DONE, STOPPED.
- IDLE:
  - play=1 -> FETCH.
  - Otherwise stay.
- FETCH:
  - rom_addr already holds {song, entry}.
  - Next cycle -> DECODE (covers the 1-cycle ROM latency).
- DECODE: rom_data is valid.
  - END=1:
    - Pulse song_done.
    - Set entry to 0.
    - loop_enable=1 -> FETCH.
    - loop_enable=0 -> STOPPED.
  - END=0:
    - Register the three fields.
    - Go to LOAD.
- LOAD:
  - load_new_note=1 for exactly this cycle.
  - Increment entry.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - done_with_note=1 -> FETCH if play=1, else IDLE.
  - Otherwise stay.
  - The player may assert done 1 cycle after load (duration 0); that pulse must be caught here.
- STOPPED:
  - Stay until new_song.
  - The play level alone does not restart.
- Entry wrap: incrementing past 2^ADDR_W-1 is treated as an implicit END:
  - Entry becomes 0.
  - song_done pulses in the LOAD cycle.
  - Loop/stop rule applies after WAIT_DONE completes.
- new_song (highest priority, any state):
  - Latch song_sel.
  - Entry=0, song_done=0.
  - Next state FETCH if play=1, else IDLE.
  - An in-flight load pulse that same cycle is suppressed.
- done_with_note outside WAIT_DONE is ignored.
- play falling in FETCH, DECODE or LOAD:
  - The current entry completes through LOAD.
  - Gating is applied at the WAIT_DONE exit.
  - The note player's own pause handles audible silence.
- Output registers:
  - Note fields change only in DECODE->LOAD and hold until the next load.
  - rom_addr is {latched song, entry}, updated with entry.
- Asynchronous reset mid-note: all state cleared immediately; no load or song_done pulse emitted.
- Throughput: at most one load every 4 cycles (FETCH, DECODE, LOAD, WAIT_DONE min 1).

Decomposition:
- Shared package holds:
  - state encoding constants;
  - ROM field positions END_BIT=15, SIDE_MSB/LSB=14/13, NOTE_MSB/LSB=12/7, DUR_MSB/LSB=6/1;
  - ROM word width 16.
- No sub-module required: the ROM stays external (song_rom), so the bench drives rom_data directly.
- The entry counter is inline dffre-style logic.

Test Plan:
- Basic sequence:
  - Stimulus: ROM entries 0: note 20, dur 4, side 2'b11; 1: note 25, dur 2, side 2'b01; 2: END. play=1, new_song with song_sel=1.
  - Required response: rom_addr 0x80, 0x81, 0x82. Two load pulses with the exact fields, each ≥1 cycle after the previous done. song_done pulses once. State ends in STOPPED.
- Loop:
  - Stimulus: same song, loop_enable=1.
  - Required response: after END, rom_addr returns to 0x80 and entry 0 reloads. song_done pulses on every pass.
- Zero duration:
  - Stimulus: entry dur=0; model done_with_note one cycle after load.
  - Required response: done captured, next fetch proceeds, no hang.
- Play gating:
  - Stimulus: drop play during WAIT_DONE, then deliver done.
  - Required response: → IDLE, no fetch. Raise play → FETCH of the next entry (not the same one).
- new_song mid-note:
  - Stimulus: pulse new_song with song_sel=2 while in WAIT_DONE with entry 5.
  - Required response: rom_addr=0x100 next cycle. A later stale done_with_note is ignored if it arrives outside WAIT_DONE.
- Wrap and reset:
  - Stimulus: a song with no END and all 128 entries dur 1.
  - Required response: song_done pulses on entry 127's load, entry 0 follows. Async reset asserted mid-LOAD clears load_new_note in the same cycle.
